// File: rtl/sigmoid_pkg.sv
// rtl/sigmoid_pkg.sv - fixed-point formats, segment thresholds and offsets for sigmoid_fx
package sigmoid_pkg;

  // Q4.12: 12 fraction bits, 1.0 = 4096
  localparam int          Q_FRAC  = 12;
  localparam logic [15:0] ONE     = 16'h1000;

  // |x| segment boundaries in Q4.12 units
  localparam logic [15:0] T_SAT   = 16'd20480;  // 5.0
  localparam logic [15:0] T_MID   = 16'd9728;   // 2.375
  localparam logic [15:0] T_LOW   = 16'd4096;   // 1.0

  // Segment intercepts in Q4.12 units
  localparam logic [12:0] OFF_HI  = 13'd3456;   // 0.84375
  localparam logic [12:0] OFF_MID = 13'd2560;   // 0.625
  localparam logic [12:0] OFF_LOW = 13'd2048;   // 0.5

  // Saturated positive-half output (1.0 on a 13-bit p)
  localparam logic [12:0] P_SAT   = 13'h1000;

  typedef enum logic [1:0] {
    SEG_LOW = 2'd0,
    SEG_MID = 2'd1,
    SEG_HI  = 2'd2,
    SEG_SAT = 2'd3
  } seg_e;

  // Classify a non-negative magnitude into one of the four PLAN segments
  function automatic seg_e seg_of(input logic [15:0] a);
    seg_e s;
    if (a >= T_SAT) begin
      s = SEG_SAT;
    end else if (a >= T_MID) begin
      s = SEG_HI;
    end else if (a >= T_LOW) begin
      s = SEG_MID;
    end else begin
      s = SEG_LOW;
    end
    return s;
  endfunction

endpackage

// File: rtl/sigmoid_plan_seg.sv
// rtl/sigmoid_plan_seg.sv - combinational PLAN segment evaluation for the positive half of sigmoid
module sigmoid_plan_seg
  import sigmoid_pkg::*;
(
  input  logic [15:0] a,
  output logic [12:0] p
);

  seg_e seg;

  // Segment select; each slope is a power of two so the term is a pure bit slice.
  // Slices are sized to the largest magnitude that can reach each segment.
  always_comb begin
    seg = seg_of(a);
    p   = P_SAT;
    case (seg)
      SEG_SAT: p = P_SAT;
      SEG_HI:  p = {2'b00, a[15:5]} + OFF_HI;   // a < 20480 so a>>5 <= 639
      SEG_MID: p = a[15:3] + OFF_MID;           // a < 9728  so a>>3 <= 1215
      SEG_LOW: p = {1'b0, a[13:2]} + OFF_LOW;   // a < 4096  so a>>2 <= 1023
      default: p = P_SAT;
    endcase
  end

endmodule

// File: rtl/sigmoid_fx.sv
// rtl/sigmoid_fx.sv - 2-stage pipelined Q4.12 logistic function using 4-segment PLAN and symmetry
module sigmoid_fx
  import sigmoid_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        x_valid,
  input  logic [15:0] x,
  output logic        y_valid,
  output logic [15:0] y
);

  logic        sign_q;
  logic [15:0] a_q;
  logic        valid_q;
  logic [15:0] x_abs;
  logic [12:0] p;

  // Magnitude of x; -8.0 (0x8000) negates to itself, read as unsigned 8.0
  always_comb begin
    x_abs = x;
    if (x[15]) begin
      x_abs = ~x + 16'd1;
    end
  end

  // Stage 1: capture sign and magnitude
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
      a_q    <= '0;
    end else begin
      sign_q <= x[15];
      a_q    <= x_abs;
    end
  end

  sigmoid_plan_seg u_plan_seg (
    .a (a_q),
    .p (p)
  );

  // Stage 2: mirror the positive-half result for negative inputs (p <= 1.0, so no underflow)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= '0;
    end else if (sign_q) begin
      y <= ONE - {3'b000, p};
    end else begin
      y <= {3'b000, p};
    end
  end

  // Valid shift register tracking the two data stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      valid_q <= x_valid;
      y_valid <= valid_q;
    end
  end

endmodule

// File: tb/tb_sigmoid_fx.sv
// tb/tb_sigmoid_fx.sv - self-checking bench for sigmoid_fx
module tb_sigmoid_fx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        x_valid;
  logic [15:0] x;
  logic        y_valid;
  logic [15:0] y;

  always #5 clk = ~clk;

  sigmoid_fx dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .x_valid (x_valid),
    .x       (x),
    .y_valid (y_valid),
    .y       (y)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: PLAN on the real magnitude, scaled to Q4.12, mirrored for x < 0
  function automatic int model_y(input logic [15:0] xv);
    int  xi;
    real ax;
    int  p;
    xi = int'($signed(xv));
    ax = (xi < 0) ? -real'(xi) / 4096.0 : real'(xi) / 4096.0;
    if (ax >= 5.0)        p = 4096;
    else if (ax >= 2.375) p = int'($floor(ax * 0.03125 * 4096.0)) + 3456;
    else if (ax >= 1.0)   p = int'($floor(ax * 0.125 * 4096.0)) + 2560;
    else                  p = int'($floor(ax * 0.25 * 4096.0)) + 2048;
    return (xi < 0) ? 4096 - p : p;
  endfunction

  int          exp_q[$];
  logic [15:0] x_q[$];
  string       tag_q[$];
  logic [15:0] y_of [0:65535];
  bit          sweep_on = 1'b0;
  real         err_max = 0.0;
  real         err_sum = 0.0;
  int          err_n = 0;
  int          y_max = 0;

  // Scoreboard: every y_valid must match the oldest outstanding sample
  always @(negedge clk) begin
    int          e;
    int          xi;
    logic [15:0] xv;
    string       t;
    real         ideal, d;
    if (rst_n && y_valid) begin
      if (exp_q.size() == 0) begin
        check("stale_y_valid", 32'd1, 32'd0);
      end else begin
        e  = exp_q.pop_front();
        xv = x_q.pop_front();
        t  = tag_q.pop_front();
        check(t, {16'h0, y}, e);
        if (int'(y) > y_max) y_max = int'(y);
        if (sweep_on) begin
          y_of[xv] = y;
          xi    = int'($signed(xv));
          ideal = 1.0 / (1.0 + $exp(-real'(xi) / 4096.0));
          d     = real'(y) / 4096.0 - ideal;
          if (d < 0.0) d = -d;
          if (d > err_max) err_max = d;
          err_sum += d;
          err_n++;
        end
      end
    end
  end

  task automatic drive(input logic [15:0] v, input bit vld, input string tag, input int e);
    @(posedge clk);
    #1;
    x       = v;
    x_valid = vld;
    if (vld) begin
      exp_q.push_back(e);
      x_q.push_back(v);
      tag_q.push_back(tag);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(16'($urandom), 1'b0, "", 0);
  endtask

  logic [15:0] key_x [9] = '{16'h0000, 16'h1000, 16'hF000, 16'h2000, 16'h3000,
                             16'h5000, 16'h7FFF, 16'hB000, 16'h8000};
  logic [15:0] key_y [9] = '{16'h0800, 16'h0C00, 16'h0400, 16'h0E00, 16'h0F00,
                             16'h1000, 16'h1000, 16'h0000, 16'h0000};

  initial begin
    int          lat;
    logic [15:0] v;
    logic [15:0] nv;

    rst_n   = 1'b0;
    x_valid = 1'b0;
    x       = '0;

    // Reset held with random activity on the inputs
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      x       = 16'($urandom);
      x_valid = 1'($urandom);
      @(negedge clk);
      check("reset_y", {16'h0, y}, 32'h0);
      check("reset_y_valid", {31'h0, y_valid}, 32'h0);
    end
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    rst_n   = 1'b1;
    idle(2);

    // First sample after reset: y_valid exactly two clocks later
    drive(16'h1000, 1'b1, "first_value", 32'h0C00);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) x_valid = 1'b0;
      lat++;
      if (y_valid) break;
    end
    check("first_latency", lat, 2);
    idle(3);

    // Key points and saturation, back to back
    for (int i = 0; i < 9; i++) drive(key_x[i], 1'b1, $sformatf("key_%04h", key_x[i]), int'(key_y[i]));
    idle(4);

    // Random values with random bubbles
    for (int i = 0; i < 300; i++) begin
      v = 16'($urandom);
      drive(v, 1'($urandom), "random", model_y(v));
    end
    idle(4);

    // Alternating bubbles with an asynchronous reset pulse mid-stream
    for (int i = 0; i < 60; i++) begin
      v = 16'($urandom);
      drive(v, (i % 2) == 0, "bubble", model_y(v));
      if (i == 30) begin
        #3;
        rst_n   = 1'b0;
        x_valid = 1'b0;
        exp_q.delete();
        x_q.delete();
        tag_q.delete();
        @(negedge clk);
        check("midreset_y", {16'h0, y}, 32'h0);
        check("midreset_y_valid", {31'h0, y_valid}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
    end
    idle(4);
    check("drain_before_sweep", exp_q.size(), 0);

    // Exhaustive sweep, one sample per clock
    sweep_on = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      v = 16'(i);
      drive(v, 1'b1, "sweep", model_y(v));
    end
    idle(4);
    sweep_on = 1'b0;

    check("sweep_count", err_n, 65536);
    check("max_err_le_0p02", {31'h0, err_max <= 0.02}, 32'd1);
    check("mean_err_le_0p01", {31'h0, (err_n > 0) && (err_sum / real'(err_n) <= 0.01)}, 32'd1);
    check("y_max_le_one", {31'h0, y_max <= 4096}, 32'd1);

    // Symmetry y(x) + y(-x) == 1.0 over sampled pairs
    for (int i = 0; i < 200; i++) begin
      v = 16'($urandom);
      if (v == 16'h8000) v = 16'h0001;
      nv = ~v + 16'd1;
      check($sformatf("symmetry_%04h", v), 32'(y_of[v]) + 32'(y_of[nv]), 32'h1000);
    end

    check("drain_end", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
